instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
- REQ-001: Parameter ADDR_W, default 8, instruction address width; matches the program counter width.
- REQ-002: Parameter INSTR_W, default 16, instruction word width.
- REQ-003: Port clk, input, 1, the single clock; all state updates on the rising edge.
- REQ-004: Port rst, input, 1, reset, asynchronous and active-high.
- REQ-005: Port pc_addr, input, ADDR_W, current program counter value.
- REQ-006: Port pc_en, output, 1, advances the program counter by one this cycle.
- REQ-007: Port flush, input, 1, asserted in the same cycle as a program counter overwrite; kills all fetched and in-flight work.
- REQ-008: Port imem_rd, output, 1, instruction memory read strobe.
- REQ-009: Port imem_addr, output, ADDR_W, instruction memory read address.
- REQ-010: Port imem_data, input, INSTR_W, read data, valid exactly one cycle after imem_rd.
- REQ-011: Port out_valid, output, 1, head instruction available to decode.
- REQ-012: Port out_ready, input, 1, decode accepts the head instruction.
- REQ-013: Port out_instr, output, INSTR_W, head instruction word.
- REQ-014: Port out_pc, output, ADDR_W, address the head instruction was fetched from.

Function
- REQ-015: Block SHALL hold a 2-entry in-order instruction buffer, an in-flight flag and an in-flight address register.
- REQ-016: Pop SHALL occur on a cycle where out_valid and out_ready are both high; out_valid SHALL equal buffer occupancy != 0.
- REQ-017: Issue SHALL occur when flush is low and (occupancy + inflight - pop) < 2; imem_rd and pc_en SHALL both equal issue.
- REQ-018: imem_addr SHALL equal pc_addr combinationally; on issue, pc_addr SHALL be captured as the in-flight address.
- REQ-019: The cycle after an issue, imem_data and the captured address SHALL be pushed as one entry, unless a flush occurred in between.
- REQ-020: Sustained throughput SHALL be one instruction per cycle when out_ready is held high; first out_valid SHALL be 2 cycles after reset release.
- REQ-021: Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
- REQ-022: Occupancy SHALL never exceed 2; push into a full buffer SHALL be impossible by construction.
- REQ-023: On flush, occupancy SHALL clear at the next edge, no issue SHALL occur that cycle, and any in-flight return SHALL be discarded.
- REQ-024: Flush SHALL take priority over simultaneous pop and push.
- REQ-025: out_instr and out_pc SHALL stay stable while out_valid is high and out_ready is low.

Reset
- REQ-026: While rst is high, occupancy, inflight, out_valid, imem_rd, pc_en and the stall counter SHALL be 0.
- REQ-027: out_instr and out_pc SHALL read 0 in reset.
- REQ-028: Reset mid-fetch SHALL drop the in-flight return; the first issue SHALL be the first clock edge after rst deasserts.

Configuration
- REQ-029: Macro INSTR_FETCH_PERF_CNT_EN SHALL, when defined, add output stall_cnt (16 bits, saturating at 0xFFFF), incremented every cycle out_valid is high and out_ready is low.
- REQ-030: Without INSTR_FETCH_PERF_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
- REQ-031: Package protocore_pkg SHALL hold ADDR_W, INSTR_W defaults and the FETCH_DEPTH = 2 constant.
- REQ-032: The buffer SHALL be a sub-module fetch_fifo (push, pop, flush, occupancy out); issue and in-flight logic stay in instr_fetch.

Verification
- REQ-033: Reset release, out_ready=1, memory returns addr^0xA500 -> out_pc 0,1,2,... one per cycle from cycle 2, out_instr 0xA500,0xA501,...
- REQ-034: out_ready=0 for 5 cycles -> exactly 2 entries buffered, pc_en low after 2 issues, and stall_cnt=5 when the macro is defined.
- REQ-035: Flush with occupancy 2 and one in-flight read, pc_addr reloaded to 0x40 -> next out_pc = 0x40 and no pre-flush entry appears.
- REQ-036: Pc_addr wraps from 0xFF -> out_pc 0xFF followed by 0x00, with no gap.
- REQ-037: Async rst pulse mid-stream between edges -> out_valid drops immediately and the fetch restarts cleanly.
- REQ-038: Random out_ready over 1000 cycles -> out_pc sequence contiguous, no duplicates or losses, occupancy <= 2.

Source files
------------

// File: rtl/protocore_pkg.sv
// Shared constants for the protocore fetch front end.
package protocore_pkg;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned FETCH_DEPTH = 2;
    localparam int unsigned OCC_W       = $clog2(FETCH_DEPTH + 1);
    localparam int unsigned STALL_W     = 16;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order instruction buffer; entry0 is always the head.
module fetch_fifo
    import protocore_pkg::*;
#(
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [OCC_W-1:0]  occupancy,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;

    assign head = entry0;

    // Flush wins over push/pop; a push with a pop of the last entry lands in entry0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
            entry0    <= '0;
            entry1    <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occupancy == OCC_W'(0)) entry0 <= push_data;
                    else                        entry1 <= push_data;
                    occupancy <= occupancy + OCC_W'(1);
                end
                2'b01: begin
                    entry0    <= entry1;
                    occupancy <= occupancy - OCC_W'(1);
                end
                2'b11: begin
                    if (occupancy == OCC_W'(1)) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one-cycle-latency memory reads into a 2-entry buffer.
// Optional stall counter output enabled by INSTR_FETCH_PERF_CNT_EN.
module instr_fetch #(
    parameter int unsigned ADDR_W  = protocore_pkg::ADDR_W,
    parameter int unsigned INSTR_W = protocore_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_en,
    input  logic               flush,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    import protocore_pkg::*;

    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
    localparam int unsigned LVL_W   = OCC_W + 1;

    logic               inflight;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [OCC_W-1:0]   occupancy;
    logic [LVL_W-1:0]   level;
    logic               pop;
    logic               issue;
    logic [ENTRY_W-1:0] head;

    assign out_valid = (occupancy != '0);
    assign pop       = out_valid & out_ready;

    // Buffered plus in-flight work after this cycle's pop must leave room for one more.
    assign level     = LVL_W'(occupancy) + LVL_W'(inflight) - LVL_W'(pop);
    assign issue     = !rst && !flush && (level < LVL_W'(FETCH_DEPTH));
    assign imem_rd   = issue;
    assign pc_en     = issue;
    assign imem_addr = pc_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc_addr;
        end
    end

    // A flush in the return cycle discards the data inside the buffer.
    fetch_fifo #(
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({inflight_pc, imem_data}),
        .pop       (pop),
        .flush     (flush),
        .occupancy (occupancy),
        .head      (head)
    );

    assign out_pc    = head[ENTRY_W-1:INSTR_W];
    assign out_instr = head[INSTR_W-1:0];

`ifdef INSTR_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch against a queue-based fetch model.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pc_addr = 8'h00;
    logic        pc_en;
    logic        flush = 1'b0;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    instr_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .pc_addr   (pc_addr),
        .pc_en     (pc_en),
        .flush     (flush),
        .imem_rd   (imem_rd),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc)
`ifdef INSTR_FETCH_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency; word = address ^ 0xA500.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= {8'h00, imem_addr} ^ 16'hA500;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: buffered fetch addresses, one pending read, stall count.
    int unsigned buf_q[$];
    bit          pend_v = 1'b0;
    logic [7:0]  pend_pc = 8'h00;
    int unsigned stall_model = 0;
    logic [7:0]  next_accept = 8'h00;
    int          outstanding = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        buf_q.delete();
        pend_v      = 1'b0;
        stall_model = 0;
        next_accept = 8'h00;
        outstanding = 0;
        pc_addr     = 8'h00;
    endtask

    // One clock cycle: drive, compare against the model, then advance model and PC.
    task automatic cycle(input logic rdy, input logic fl, input logic [7:0] fl_pc);
        bit   exp_valid;
        bit   exp_pop;
        bit   exp_issue;
        logic pc_en_s;
        out_ready = rdy;
        flush     = fl;
        #1;
        exp_valid = (buf_q.size() != 0);
        exp_pop   = exp_valid && rdy;
        exp_issue = !fl && ((buf_q.size() + int'(pend_v) - int'(exp_pop)) < 2);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_pc", 32'(out_pc), buf_q[0]);
            check("out_instr", 32'(out_instr), buf_q[0] ^ 32'hA500);
        end
        check("imem_rd", 32'(imem_rd), 32'(exp_issue));
        check("pc_en", 32'(pc_en), 32'(exp_issue));
        check("imem_addr", 32'(imem_addr), 32'(pc_addr));
`ifdef INSTR_FETCH_PERF_CNT_EN
        check("stall_cnt", 32'(stall_cnt), stall_model);
`endif
        if (out_valid && rdy) begin
            check("seq_pc", 32'(out_pc), 32'(next_accept));
            next_accept = next_accept + 8'd1;
            outstanding--;
        end
        if (pc_en) outstanding++;
        check("occ_le2", 32'(outstanding <= 2), 32'd1);
        pc_en_s = pc_en;
        @(posedge clk);
        #1;
        if (exp_valid && !rdy && stall_model < 32'hFFFF) stall_model++;
        if (fl) begin
            buf_q.delete();
            pend_v      = 1'b0;
            pc_addr     = fl_pc;
            next_accept = fl_pc;
            outstanding = 0;
        end else begin
            if (exp_pop) void'(buf_q.pop_front());
            if (pend_v) buf_q.push_back(32'(pend_pc));
            pend_v  = exp_issue;
            pend_pc = pc_addr;
            if (pc_en_s) pc_addr = pc_addr + 8'd1;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_imem_rd", 32'(imem_rd), 32'd0);
        check("rst_pc_en", 32'(pc_en), 32'd0);
        check("rst_out_pc", 32'(out_pc), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        model_reset();
        rst = 1'b0;

        // Streaming with out_ready high: out_pc 0,1,2,... from cycle 2
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'h00);

        // Stall for 5 cycles: buffer fills to 2, issue stops
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
        check("stall_buffered", 32'(buf_q.size()), 32'd2);
        check("stall_outstanding", 32'(outstanding), 32'd2);
        check("stall_pc_en", 32'(pc_en), 32'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
        check("stall_cnt5", 32'(stall_cnt), 32'd5);
`endif

        // One pop with refill, then flush with a reload to 0x40
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h40);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00);

        // Flush straight out of a full buffer
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h80);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);

        // PC wrap 0xFF -> 0x00 without a gap
        cycle(1'b1, 1'b1, 8'hFC);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'h00);

        // Asynchronous reset pulse between edges
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_imem_rd", 32'(imem_rd), 32'd0);
        check("arst_out_pc", 32'(out_pc), 32'd0);
        check("arst_out_instr", 32'(out_instr), 32'd0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00);

        // Random backpressure with occasional flushes
        for (int i = 0; i < 1000; i++) begin
            logic       r;
            logic       f;
            logic [7:0] p;
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 49) == 0);
            p = 8'($urandom);
            cycle(r, f, p);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
